// File: rtl/euler_pkg.sv
// Shared definitions for the Euler step sequencer and its time accumulator.
// Time quantities use Q16.16 unsigned fixed point, so 0x00010000 is 1.0.
package euler_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] ISSUE   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] ADVANCE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] DRAIN   = 3'd6;

    // States in which a run is actively being set up or stepped.
    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == LOAD) || (st == ISSUE) || (st == WAIT) || (st == ADVANCE);
    endfunction

endpackage

// File: rtl/euler_time_acc.sv
// Holds the independent variable t. Adds h with one extra bit so that a
// carry-out saturates t at all-ones and raises a sticky overflow flag
// instead of wrapping back to a small time.
module euler_time_acc
    import euler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] t_start,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] t_end,
    output logic [DATA_W-1:0] t_cur,
    output logic              t_reach,
    output logic              ovf
);

    logic [DATA_W:0] t_sum;
    logic            carry;

    // Candidate next t and whether taking this step ends the interval;
    // a carry-out always counts as reaching the end.
    always_comb begin
        t_sum   = {1'b0, t_cur} + {1'b0, h};
        carry   = t_sum[DATA_W];
        t_reach = carry || (t_sum[DATA_W-1:0] >= t_end);
    end

    // t register and sticky overflow: restart from t_start on load, step on advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            t_cur <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            t_cur <= t_start;
            ovf   <= 1'b0;
        end else if (advance) begin
            if (carry) begin
                t_cur <= '1;
                ovf   <= 1'b1;
            end else begin
                t_cur <= t_sum[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/euler_step_sequencer.sv
// Sequences one Euler step at a time between the run-control FSM and the
// update datapath, tracking t and the step count, and returning a single
// final_done pulse when the interval or the step budget runs out.
module euler_step_sequencer
    import euler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic [DATA_W-1:0] t_start,
    input  logic [DATA_W-1:0] t_end,
    input  logic [DATA_W-1:0] step_h,
    input  logic [CNT_W-1:0]  max_steps,
    input  logic              step_ack,
    output logic              step_req,
    output logic [DATA_W-1:0] t_cur,
    output logic [CNT_W-1:0]  step_cnt,
    output logic              busy,
    output logic              final_done,
    output logic              t_ovf
);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [DATA_W-1:0] t_end_q;
    logic [DATA_W-1:0] h_q;
    logic [CNT_W-1:0]  max_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              t_reach;

    assign cnt_inc = step_cnt + CNT_W'(1);

    // Next-state logic; in WAIT a dropped run_en wins over a coincident ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run_en) state_next = LOAD;
            LOAD:    if ((max_steps == '0) || (t_start >= t_end)) state_next = DONE;
                     else state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (!run_en) state_next = IDLE;
                     else if (step_ack) state_next = ADVANCE;
            ADVANCE: if ((cnt_inc == max_q) || t_reach) state_next = DONE;
                     else state_next = ISSUE;
            DONE:    state_next = DRAIN;
            DRAIN:   if (!run_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register with outputs registered from the next state, so each
    // output is high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            step_req   <= 1'b0;
            final_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            step_req   <= (state_next == ISSUE);
            final_done <= (state_next == DONE);
            busy       <= is_busy_state(state_next);
        end
    end

    // Run parameters are captured once in LOAD and held for the whole run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            t_end_q <= '0;
            h_q     <= '0;
            max_q   <= '0;
        end else if (state == LOAD) begin
            t_end_q <= t_end;
            h_q     <= step_h;
            max_q   <= max_steps;
        end
    end

    // Completed-step counter: cleared at the start of each run, bumped per step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            step_cnt <= '0;
        end else if (state == LOAD) begin
            step_cnt <= '0;
        end else if (state == ADVANCE) begin
            step_cnt <= cnt_inc;
        end
    end

    euler_time_acc #(
        .DATA_W (DATA_W)
    ) u_time_acc (
        .clk     (clk),
        .rst     (rst),
        .load    (state == LOAD),
        .advance (state == ADVANCE),
        .t_start (t_start),
        .h       (h_q),
        .t_end   (t_end_q),
        .t_cur   (t_cur),
        .t_reach (t_reach),
        .ovf     (t_ovf)
    );

endmodule
